// File: rtl/cond_flag_unit.sv
// cond_flag_unit: pipelined branch-condition flag.
//   Stage 1 captures busOut and the C2 condition field on a CONin edge.
//   Stage 2 evaluates the captured operands one edge later and registers the
//   result in conditionMet, pulsing con_valid alongside each update.
// Ports:
//   clock        - system clock, rising edge
//   clear        - asynchronous active-high reset
//   busOut       - bus value under test (sign bit = DATA_W-1)
//   C2           - condition code field
//   CONin        - capture strobe
//   conditionMet - registered condition result, held between evaluations
//   con_valid    - one-cycle pulse per conditionMet update
//   cond_err     - sticky flag, set when a reserved code is evaluated
//   eval_count   - saturating count of evaluations
//   taken_count  - saturating count of evaluations that returned 1
module cond_flag_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] busOut,
  input  logic [3:0]        C2,
  input  logic              CONin,
  output logic              conditionMet,
  output logic              con_valid,
  output logic              cond_err,
  output logic [CNT_W-1:0]  eval_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [3:0] {
    COND_ZERO   = 4'b0000,
    COND_NZERO  = 4'b0001,
    COND_PLUS   = 4'b0010,
    COND_MINUS  = 4'b0011,
    COND_GT     = 4'b0100,
    COND_LE     = 4'b0101,
    COND_ALWAYS = 4'b0110,
    COND_NEVER  = 4'b0111
  } cond_e;

  logic [DATA_W-1:0] bus_q;
  logic [3:0]        c_q;
  logic              pend_q;
  logic              met_q, met_d;
  logic              valid_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  eval_q, eval_d;
  logic [CNT_W-1:0]  taken_q, taken_d;

  logic              zero, neg, result;

  // Condition evaluation on the captured operands only.
  always_comb begin
    zero   = (bus_q == '0);
    neg    = bus_q[DATA_W-1];
    result = 1'b0;
    if (!c_q[3]) begin
      case (cond_e'(c_q))
        COND_ZERO:   result = zero;
        COND_NZERO:  result = !zero;
        COND_PLUS:   result = !neg;
        COND_MINUS:  result = neg;
        COND_GT:     result = !neg && !zero;
        COND_LE:     result = neg || zero;
        COND_ALWAYS: result = 1'b1;
        COND_NEVER:  result = 1'b0;
        default:     result = 1'b0;
      endcase
    end
  end

  // Next-state for the stage-2 outputs; everything holds unless pend_q.
  always_comb begin
    met_d   = met_q;
    err_d   = err_q;
    eval_d  = eval_q;
    taken_d = taken_q;
    if (pend_q) begin
      met_d = result;
      if (c_q[3])
        err_d = 1'b1;
      if (eval_q != '1)
        eval_d = eval_q + CNT_W'(1);
      if (result && (taken_q != '1))
        taken_d = taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus_q   <= '0;
      c_q     <= '0;
      pend_q  <= 1'b0;
      met_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      eval_q  <= '0;
      taken_q <= '0;
    end else begin
      if (CONin) begin
        bus_q <= busOut;
        c_q   <= C2;
      end
      pend_q  <= CONin;
      met_q   <= met_d;
      valid_q <= pend_q;
      err_q   <= err_d;
      eval_q  <= eval_d;
      taken_q <= taken_d;
    end
  end

  assign conditionMet = met_q;
  assign con_valid    = valid_q;
  assign cond_err     = err_q;
  assign eval_count   = eval_q;
  assign taken_count  = taken_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit. Two instances share stimulus:
// one with default counter width, one with CNT_W=4 for saturation.
module tb_cond_flag_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] busOut;
  logic [3:0]  C2;
  logic        CONin;

  logic        cm, vld, err;
  logic [15:0] evc, tkc;
  logic        cm_s, vld_s, err_s;
  logic [3:0]  evc_s, tkc_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cond_flag_unit #(.DATA_W(32), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .busOut(busOut), .C2(C2), .CONin(CONin),
    .conditionMet(cm), .con_valid(vld), .cond_err(err),
    .eval_count(evc), .taken_count(tkc)
  );

  cond_flag_unit #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clock(clock), .clear(clear), .busOut(busOut), .C2(C2), .CONin(CONin),
    .conditionMet(cm_s), .con_valid(vld_s), .cond_err(err_s),
    .eval_count(evc_s), .taken_count(tkc_s)
  );

  // Reference model: captured requests queued with the edge at which they
  // resolve; statistics kept as plain unbounded integers.
  typedef struct {
    int          due;
    logic [31:0] b;
    logic [3:0]  c;
  } req_t;

  req_t q[$];
  int   edge_no = 0;
  bit   cm_m, vld_m, err_m;
  int   evals_m, taken_m;

  function automatic bit ref_eval(input logic [31:0] b, input logic [3:0] c);
    int v;
    v = $signed(b);
    case (c)
      4'd0:    return v == 0;
      4'd1:    return v != 0;
      4'd2:    return v >= 0;
      4'd3:    return v < 0;
      4'd4:    return v > 0;
      4'd5:    return v <= 0;
      4'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cm_m = 0; vld_m = 0; err_m = 0; evals_m = 0; taken_m = 0;
  endtask

  task automatic check_all();
    chk("conditionMet", 32'(cm), 32'(cm_m));
    chk("con_valid", 32'(vld), 32'(vld_m));
    chk("cond_err", 32'(err), 32'(err_m));
    chk("eval_count", 32'(evc), 32'(sat(evals_m, 16)));
    chk("taken_count", 32'(tkc), 32'(sat(taken_m, 16)));
    chk("sat_conditionMet", 32'(cm_s), 32'(cm_m));
    chk("sat_con_valid", 32'(vld_s), 32'(vld_m));
    chk("sat_eval_count", 32'(evc_s), 32'(sat(evals_m, 4)));
    chk("sat_taken_count", 32'(tkc_s), 32'(sat(taken_m, 4)));
  endtask

  // Drive one cycle of inputs, advance the model across the rising edge,
  // then compare on the falling edge.
  task automatic step(input bit con, input logic [31:0] b, input logic [3:0] c);
    req_t r;
    CONin = con; busOut = b; C2 = c;
    @(posedge clock);
    edge_no++;
    vld_m = 0;
    if (q.size() > 0 && q[0].due == edge_no) begin
      r = q.pop_front();
      cm_m = ref_eval(r.b, r.c);
      vld_m = 1;
      if (r.c >= 4'd8) err_m = 1;
      evals_m++;
      if (cm_m) taken_m++;
    end
    if (con) q.push_back('{due: edge_no + 1, b: b, c: c});
    @(negedge clock);
    check_all();
  endtask

  // Clear asserted together with CONin: outputs drop at once, nothing captured.
  task automatic do_clear();
    clear = 1'b1; CONin = 1'b1; busOut = '0; C2 = 4'd6;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    @(negedge clock);
    check_all();
    clear = 1'b0; CONin = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [3:0] c,
                          input logic [31:0] b, input bit exp);
    step(1'b1, b, c);
    step(1'b0, $urandom, 4'($urandom));
    chk(tag, 32'(cm), 32'(exp));
    chk({tag, "_valid"}, 32'(vld), 32'd1);
    step(1'b0, $urandom, 4'($urandom));
    chk({tag, "_valid_drop"}, 32'(vld), 32'd0);
  endtask

  function automatic logic [31:0] rand_bus();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 9));
      2:       return 32'h8000_0000 | 32'($urandom);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] h_evc;
    clear = 1'b1; CONin = 1'b0; busOut = '0; C2 = '0;
    model_reset();
    @(negedge clock);
    check_all();
    @(negedge clock);
    clear = 1'b0;

    // Legacy codes
    directed("brzr_zero", 4'b0000, 32'd0, 1'b1);
    directed("brnz_zero", 4'b0001, 32'd0, 1'b0);
    directed("brpl_neg", 4'b0010, 32'h8000_0000, 1'b0);
    directed("brmi_neg", 4'b0011, 32'h8000_0000, 1'b1);
    // Extended codes
    directed("gt_five", 4'b0100, 32'd5, 1'b1);
    directed("gt_zero", 4'b0100, 32'd0, 1'b0);
    directed("le_zero", 4'b0101, 32'd0, 1'b1);
    directed("always", 4'b0110, 32'h1234, 1'b1);
    directed("never", 4'b0111, 32'h1234, 1'b0);
    chk("err_before_reserved", 32'(err), 32'd0);
    directed("reserved", 4'b1010, 32'd0, 1'b0);
    chk("err_set", 32'(err), 32'd1);
    directed("after_reserved", 4'b0110, 32'd0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    // Back-to-back
    do_clear();
    step(1'b1, 32'd0, 4'b0000);
    step(1'b1, 32'd7, 4'b0000);
    chk("b2b_first", 32'(cm), 32'd1);
    step(1'b1, 32'd0, 4'b0001);
    chk("b2b_second", 32'(cm), 32'd0);
    step(1'b0, 32'd0, 4'b0000);
    chk("b2b_third", 32'(cm), 32'd0);
    chk("b2b_valid3", 32'(vld), 32'd1);
    chk("b2b_evals", 32'(evc), 32'd3);
    chk("b2b_taken", 32'(tkc), 32'd1);

    // Hold / isolation
    for (int i = 0; i < 10; i++) step(1'b0, $urandom, 4'($urandom));
    chk("hold_evals", 32'(evc), 32'd3);
    chk("hold_met", 32'(cm), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_bus(), 4'($urandom_range(0, 15)));

    // Saturation on the narrow-counter instance
    do_clear();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 4'b0110);
      if (i > 0) chk("sat_pulse", 32'(vld_s), 32'd1);
    end
    step(1'b0, 32'd0, 4'd0);
    chk("sat_evals_stop", 32'(evc_s), 32'd15);
    chk("sat_taken_stop", 32'(tkc_s), 32'd15);
    chk("sat_met", 32'(cm_s), 32'd1);

    // Mid-run reset with an evaluation in flight
    do_clear();
    for (int i = 0; i < 4; i++) step(1'b1, rand_bus(), 4'($urandom_range(0, 7)));
    h_evc = evc_s;
    chk("pre_reset_evals", 32'(h_evc), 32'd3);
    do_clear();
    step(1'b0, 32'd0, 4'd0);
    chk("post_reset_no_pulse", 32'(vld), 32'd0);
    chk("post_reset_evals", 32'(evc), 32'd0);
    step(1'b1, 32'd0, 4'd0);
    step(1'b0, 32'd0, 4'd0);
    chk("restart_evals", 32'(evc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Parametrised, clocked successor to the single-flop branch condition (CON FF) logic.
- Samples the bus value and the instruction's C2 condition field on a CONin strobe, then evaluates an extended condition set one cycle later.
- Holds the result in a registered conditionMet flag for the branch/PC-select path.
- Also reports a one-cycle result-valid pulse, a sticky illegal-condition flag and saturating evaluation/taken statistics counters for the control unit and debug.

Parameters:
DATA_W, 32, width of the bus value being tested (sign bit = bit DATA_W-1)
CNT_W, 16, width of each statistics counter

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  asynchronous, active-high reset
busOut  input  DATA_W  bus value under test (register contents driven on the bus)
C2  input  4  condition code field from the instruction
CONin  input  1  capture strobe; sampled high on a rising clock edge
conditionMet  output  1  registered condition result; holds until the next evaluation
con_valid  output  1  one-cycle pulse coincident with each conditionMet update
cond_err  output  1  sticky: set when a reserved C2 code is evaluated
eval_count  output  CNT_W  number of evaluations completed, saturating
taken_count  output  CNT_W  number of evaluations with result 1, saturating

Behaviour:
- Reset (clear=1, asynchronous): conditionMet=0, con_valid=0, cond_err=0, eval_count=0, taken_count=0; capture registers and pending bit cleared. Any in-flight evaluation is discarded. Deassertion is not gated by CONin.
- Stage 1 (capture): on a rising edge with CONin=1, register bus_q<=busOut, c_q<=C2, pend<=1. On a rising edge with CONin=0, pend<=0.
- Stage 2 (evaluate): on a rising edge with pend=1:
  - conditionMet <= eval(bus_q, c_q)
  - con_valid <= 1
  - eval_count increments
  - taken_count increments if the result is 1
- On a rising edge with pend=0: con_valid<=0; conditionMet, the counters and cond_err hold.
- Latency: result visible 2 rising edges after the CONin edge; throughput 1 evaluation/cycle. CONin held high N cycles gives N back-to-back evaluations, each using its own captured operands.
- Condition codes (z = bus_q all zeros; n = bus_q[DATA_W-1]):
  - 0000 z (brzr)
  - 0001 !z (brnz)
  - 0010 !n (brpl, >=0)
  - 0011 n (brmi, <0)
  - 0100 !n & !z (>0)
  - 0101 n | z (<=0)
  - 0110 1 (always)
  - 0111 0 (never)
  - 1000-1111 reserved: result 0, cond_err<=1 (sticky until clear)
- Codes 0000-0011 reproduce the existing CON FF truth table exactly.
- Counters saturate at 2^CNT_W-1 and do not wrap. At saturation the evaluation still completes normally: conditionMet updates and con_valid pulses.
- busOut/C2 changes while CONin=0 have no effect on any output.
- Evaluation uses only registered operands; no combinational path from busOut/C2 to any output.
- clear asserted in the same cycle as CONin: reset wins and nothing is captured.

Test Plan:
- Reset: assert clear mid-run after 3 evaluations, with pend=1 -> all outputs 0 immediately, no con_valid pulse afterward; eval_count restarts from 0.
- Legacy codes, DATA_W=32:
  - C2=0000, bus=0 -> conditionMet=1 two edges after CONin
  - C2=0001, bus=0 -> 0
  - C2=0010, bus=32'h8000_0000 -> 0
  - C2=0011, same bus -> 1
  - con_valid high exactly one cycle each
- Extended codes:
  - C2=0100, bus=5 -> 1; C2=0100, bus=0 -> 0
  - C2=0101, bus=0 -> 1
  - C2=0110 -> 1; C2=0111 -> 0
  - C2=1010 -> 0 with cond_err=1, staying 1 through later valid evaluations
- Back-to-back: CONin high 3 cycles with (bus,C2) = (0,0000), (7,0000), (0,0001) -> conditionMet 1,0,0 on consecutive edges; con_valid high 3 cycles; eval_count=3, taken_count=1.
- Hold/isolation: after an evaluation, toggle busOut and C2 for 10 cycles with CONin=0 -> conditionMet, the counters and con_valid=0 all unchanged.
- Saturation (CNT_W=4): 20 evaluations with C2=0110 -> eval_count and taken_count stop at 15; conditionMet=1 and con_valid pulses on every evaluation.
